random_spawn_generator: RTL and testbench
=========================================

Name: random_spawn_generator

Overview:
- Parametrised successor of the duck-spawn random number generator: XNOR Fibonacci LFSR of configurable width and taps, free-running every clock.
- Produces a complete duck spawn tuple (direction, start position, vertical speed) on request through a req/valid handshake.
- Start position is range-limited by rejection sampling with bounded retries; speed has a minimum floor.
- Supports runtime reseeding and recovers from the lock-up state. Sits between the game FSM (which requests a spawn) and the duck controller.

Parameters:
- LFSR_W, 16, LFSR width; must be >= 1 + POS_W + SPEED_W.
- TAPS, 16'hD008, tap mask (bits 15,14,12,3).
- SEED, 16'hACE1, substitute value used on lock-up recovery.
- POS_W, 10, start-position field width.
- POS_MIN, 0, offset added to the accepted position.
- POS_SPAN, 767, largest accepted raw position; must satisfy 2^(POS_W-1) <= POS_SPAN < 2^POS_W.
- SPEED_W, 5, speed field width.
- SPEED_MIN, 2, speed floor.
- MAX_TRIES, 8, samples before fallback; >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seed_load  in  1  load seed_in into the LFSR this cycle
- seed_in  in  LFSR_W  new seed value
- req  in  1  spawn request; sampled only in IDLE
- ready  out  1  high in IDLE
- valid  out  1  one-cycle pulse when a new tuple is presented
- direction  out  1  duck horizontal direction
- duck_start_pos  out  POS_W  start x position
- duck_vertical_speed  out  SPEED_W  vertical speed
- lockup_recovered  out  1  one-cycle pulse when SEED was substituted

Behaviour:
- Reset (synchronous, active-high): lfsr=0, state=IDLE, try counter=0, all outputs 0 (ready=1 after reset is released). rst mid-sample aborts the request and no valid is produced.
- LFSR step, every cycle:
  - fb = ~(^(lfsr & TAPS))
  - lfsr_nxt = {fb, lfsr[LFSR_W-1:1]}
- seed_load overrides the step for that cycle.
  - If seed_in is all-ones (the XNOR lock-up state), load SEED instead and pulse lockup_recovered on the next cycle.
  - If the lfsr is ever all-ones, the next value is SEED and lockup_recovered pulses.
- Field extraction from the current lfsr:
  - dir_c = lfsr[LFSR_W-1]
  - pos_c = lfsr[LFSR_W-2 -: POS_W]
  - spd_c = lfsr[SPEED_W-1:0]
- FSM states: IDLE, SAMPLE.
  - IDLE: ready=1. On req, go to SAMPLE and clear the try counter.
  - SAMPLE: ready=0; req is ignored. Each cycle, evaluate the current lfsr and increment the try counter.
    - Accept when pos_c <= POS_SPAN.
    - Otherwise, if this is sample number MAX_TRIES, force acceptance with pos_c >> 1 (always in range).
    - Otherwise reject and stay in SAMPLE.
  - On acceptance, at the same clock edge:
    - direction <= dir_c
    - duck_start_pos <= POS_MIN + accepted pos, truncated to POS_W
    - duck_vertical_speed <= max(spd_c, SPEED_MIN)
    - valid <= 1 for one cycle
    - go to IDLE
- Latency: req accepted at cycle t, with first-sample accept, gives valid high in cycle t+2. Each rejection adds 1 cycle; worst case is t+1+MAX_TRIES.
- Output registers hold their values until the next accepted sample; valid and ready are never high in the same cycle as a SAMPLE state.
- seed_load and req in the same IDLE cycle: both take effect, and the first sample uses the loaded seed.
- seed_load during SAMPLE is permitted and affects subsequent samples.

Decomposition:
- Package rng_pkg: state enum (IDLE, SAMPLE) and default LFSR_W/TAPS/SEED constants.
- One sub-module, lfsr_core: parametrised XNOR LFSR with seed load and lock-up substitution, exposing lfsr and lockup_recovered.
- The top level holds the FSM, try counter, field extraction and output registers.

Test Plan:
- Reset, then free-run with no seed_load -> lfsr sequence 0x0000, 0x8000, 0x4000, 0x2000, 0x9000; ready=1, valid=0, all outputs 0.
- seed_load=1, seed_in=0x0020, req=1 at cycle t -> valid high at t+2; direction=0, duck_start_pos=1, duck_vertical_speed=2 (floored from 0).
- seed_load=1, seed_in=0x7FE0, req=1 at cycle t -> sample 1023 rejected at t+1, 0xBFF0 accepted at t+2 -> valid at t+3; direction=1, pos=511, speed=16.
- MAX_TRIES=1, seed_in=0x7FE0 with req -> forced fallback: valid at t+2, pos=511, direction=0, speed=0 floored to 2.
- seed_in=0xFFFF with seed_load -> lfsr=0xACE1 next cycle; lockup_recovered pulses exactly once.
- req pulses during SAMPLE are ignored (exactly one valid per accepted req); rst asserted during SAMPLE -> next cycle state IDLE, outputs 0, no valid.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared types and default constants for the duck-spawn random number generator.
package rng_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SAMPLE = 1'b1
  } state_t;

  localparam int          DEF_LFSR_W = 16;
  localparam logic [15:0] DEF_TAPS   = 16'hD008;
  localparam logic [15:0] DEF_SEED   = 16'hACE1;

endpackage

// File: rtl/lfsr_core.sv
// Free-running XNOR Fibonacci LFSR with seed load and recovery from the all-ones lock-up state.
module lfsr_core
  import rng_pkg::*;
#(
  parameter int                LFSR_W = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS   = DEF_TAPS,
  parameter logic [LFSR_W-1:0] SEED   = DEF_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] lfsr,
  output logic              lockup_recovered
);

  localparam logic [LFSR_W-1:0] ALL_ONES = {LFSR_W{1'b1}};

  logic [LFSR_W-1:0] lfsr_r;
  logic [LFSR_W-1:0] lfsr_nxt_s;
  logic              lock_r;
  logic              lock_nxt_s;

  function automatic logic xnor_feedback(input logic [LFSR_W-1:0] value);
    return ~(^(value & TAPS));
  endfunction

  // Next LFSR value: seed load wins over the step; all-ones is never kept.
  always_comb begin
    lfsr_nxt_s = {xnor_feedback(lfsr_r), lfsr_r[LFSR_W-1:1]};
    lock_nxt_s = 1'b0;
    if (seed_load) begin
      if (seed_in == ALL_ONES) begin
        lfsr_nxt_s = SEED;
        lock_nxt_s = 1'b1;
      end else begin
        lfsr_nxt_s = seed_in;
        lock_nxt_s = 1'b0;
      end
    end else if (lfsr_r == ALL_ONES) begin
      lfsr_nxt_s = SEED;
      lock_nxt_s = 1'b1;
    end else begin
      lock_nxt_s = 1'b0;
    end
  end

  // LFSR and recovery-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_r <= {LFSR_W{1'b0}};
      lock_r <= 1'b0;
    end else begin
      lfsr_r <= lfsr_nxt_s;
      lock_r <= lock_nxt_s;
    end
  end

  assign lfsr             = lfsr_r;
  assign lockup_recovered = lock_r;

endmodule

// File: rtl/random_spawn_generator.sv
// Duck spawn tuple generator: req/valid handshake around a free-running LFSR,
// with rejection-sampled start position and floored vertical speed.
module random_spawn_generator
  import rng_pkg::*;
#(
  parameter int                LFSR_W    = DEF_LFSR_W,
  parameter logic [LFSR_W-1:0] TAPS      = DEF_TAPS,
  parameter logic [LFSR_W-1:0] SEED      = DEF_SEED,
  parameter int                POS_W     = 10,
  parameter int                POS_MIN   = 0,
  parameter int                POS_SPAN  = 767,
  parameter int                SPEED_W   = 5,
  parameter int                SPEED_MIN = 2,
  parameter int                MAX_TRIES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_in,
  input  logic               req,
  output logic               ready,
  output logic               valid,
  output logic               direction,
  output logic [POS_W-1:0]   duck_start_pos,
  output logic [SPEED_W-1:0] duck_vertical_speed,
  output logic               lockup_recovered
);

  // The counter only needs to reach MAX_TRIES-1: that sample is forced to accept.
  localparam int                 TRY_W       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0]   LAST_TRY    = TRY_W'(MAX_TRIES - 1);
  localparam logic [POS_W-1:0]   POS_SPAN_V  = POS_W'(POS_SPAN);
  localparam logic [POS_W-1:0]   POS_MIN_V   = POS_W'(POS_MIN);
  localparam logic [SPEED_W-1:0] SPEED_MIN_V = SPEED_W'(SPEED_MIN);

  logic [LFSR_W-1:0]  lfsr_s;
  logic               lockup_s;
  state_t             state_r;
  state_t             state_nxt_s;
  logic [TRY_W-1:0]   try_r;
  logic [TRY_W-1:0]   try_nxt_s;
  logic               dir_s;
  logic [POS_W-1:0]   pos_s;
  logic [SPEED_W-1:0] spd_s;
  logic               accept_s;
  logic [POS_W-1:0]   acc_pos_s;
  logic [POS_W-1:0]   pos_out_s;
  logic [SPEED_W-1:0] spd_out_s;
  logic               valid_r;
  logic               dir_r;
  logic [POS_W-1:0]   pos_r;
  logic [SPEED_W-1:0] spd_r;

  lfsr_core #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr_core (
    .clk              (clk),
    .rst              (rst),
    .seed_load        (seed_load),
    .seed_in          (seed_in),
    .lfsr             (lfsr_s),
    .lockup_recovered (lockup_s)
  );

  assign dir_s = lfsr_s[LFSR_W-1];
  assign pos_s = lfsr_s[LFSR_W-2 -: POS_W];
  assign spd_s = lfsr_s[SPEED_W-1:0];

  // Handshake FSM, try counting and acceptance decision.
  always_comb begin
    state_nxt_s = state_r;
    try_nxt_s   = try_r;
    accept_s    = 1'b0;
    acc_pos_s   = pos_s;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_nxt_s = SAMPLE;
          try_nxt_s   = {TRY_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SAMPLE: begin
        if (pos_s <= POS_SPAN_V) begin
          accept_s = 1'b1;
        end else if (try_r == LAST_TRY) begin
          // Halving a POS_W-bit value always lands inside the span.
          accept_s  = 1'b1;
          acc_pos_s = {1'b0, pos_s[POS_W-1:1]};
        end else begin
          try_nxt_s = try_r + TRY_W'(1);
        end
        if (accept_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SAMPLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign pos_out_s = POS_MIN_V + acc_pos_s;
  assign spd_out_s = (spd_s < SPEED_MIN_V) ? SPEED_MIN_V : spd_s;

  // State and try counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      try_r   <= {TRY_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      try_r   <= try_nxt_s;
    end
  end

  // Output tuple registers; they hold until the next accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      dir_r   <= 1'b0;
      pos_r   <= {POS_W{1'b0}};
      spd_r   <= {SPEED_W{1'b0}};
    end else begin
      valid_r <= accept_s;
      if (accept_s) begin
        dir_r <= dir_s;
        pos_r <= pos_out_s;
        spd_r <= spd_out_s;
      end
    end
  end

  assign ready               = (state_r == IDLE);
  assign valid               = valid_r;
  assign direction           = dir_r;
  assign duck_start_pos      = pos_r;
  assign duck_vertical_speed = spd_r;
  assign lockup_recovered    = lockup_s;

endmodule

// File: tb/tb_random_spawn_generator.sv
// Bench for random_spawn_generator: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model of two configurations.
module tb_random_spawn_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;

  logic        ready_a, valid_a, dir_a, lock_a;
  logic [9:0]  pos_a;
  logic [4:0]  spd_a;
  logic        ready_b, valid_b, dir_b, lock_b;
  logic [9:0]  pos_b;
  logic [4:0]  spd_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  random_spawn_generator dut_a (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .ready(ready_a), .valid(valid_a), .direction(dir_a), .duck_start_pos(pos_a),
    .duck_vertical_speed(spd_a), .lockup_recovered(lock_a)
  );

  random_spawn_generator #(.MAX_TRIES(1)) dut_b (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .ready(ready_b), .valid(valid_b), .direction(dir_b), .duck_start_pos(pos_b),
    .duck_vertical_speed(spd_b), .lockup_recovered(lock_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_lfsr  [2];
  logic        m_lock  [2];
  logic        m_busy  [2];
  int          m_tries [2];
  logic        m_valid [2];
  logic        m_dir   [2];
  logic [9:0]  m_pos   [2];
  logic [4:0]  m_spd   [2];
  bit          m_started = 1'b0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    int ones;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      if ((i == 15 || i == 14 || i == 12 || i == 3) && v[i]) ones++;
    end
    return {((ones % 2) == 0) ? 1'b1 : 1'b0, v[15:1]};
  endfunction

  always @(posedge clk) begin : model_proc
    logic [15:0] cur;
    int pos, spd, n, mt;
    for (int k = 0; k < 2; k++) begin
      mt  = (k == 0) ? 8 : 1;
      cur = m_lfsr[k];
      if (rst) begin
        m_lfsr[k]  <= 16'h0000;
        m_lock[k]  <= 1'b0;
        m_busy[k]  <= 1'b0;
        m_tries[k] <= 0;
        m_valid[k] <= 1'b0;
        m_dir[k]   <= 1'b0;
        m_pos[k]   <= 10'd0;
        m_spd[k]   <= 5'd0;
        m_started  <= 1'b1;
      end else begin
        if (seed_load && seed_in == 16'hFFFF) begin
          m_lfsr[k] <= 16'hACE1;
          m_lock[k] <= 1'b1;
        end else if (seed_load) begin
          m_lfsr[k] <= seed_in;
          m_lock[k] <= 1'b0;
        end else if (cur == 16'hFFFF) begin
          m_lfsr[k] <= 16'hACE1;
          m_lock[k] <= 1'b1;
        end else begin
          m_lfsr[k] <= lfsr_step(cur);
          m_lock[k] <= 1'b0;
        end
        m_valid[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (req) begin
            m_busy[k]  <= 1'b1;
            m_tries[k] <= 0;
          end
        end else begin
          pos = (int'(cur) / 32) % 1024;
          spd = int'(cur) % 32;
          n   = m_tries[k] + 1;
          if (pos > 767) pos = (n == mt) ? pos / 2 : -1;
          if (pos >= 0) begin
            m_valid[k] <= 1'b1;
            m_dir[k]   <= cur[15];
            m_pos[k]   <= 10'(pos);
            m_spd[k]   <= 5'((spd < 2) ? 2 : spd);
            m_busy[k]  <= 1'b0;
          end else begin
            m_tries[k] <= n;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (m_started) begin
      check("a.ready", 32'(ready_a), 32'(!m_busy[0]));
      check("a.valid", 32'(valid_a), 32'(m_valid[0]));
      check("a.dir",   32'(dir_a),   32'(m_dir[0]));
      check("a.pos",   32'(pos_a),   32'(m_pos[0]));
      check("a.spd",   32'(spd_a),   32'(m_spd[0]));
      check("a.lock",  32'(lock_a),  32'(m_lock[0]));
      check("b.ready", 32'(ready_b), 32'(!m_busy[1]));
      check("b.valid", 32'(valid_b), 32'(m_valid[1]));
      check("b.dir",   32'(dir_b),   32'(m_dir[1]));
      check("b.pos",   32'(pos_b),   32'(m_pos[1]));
      check("b.spd",   32'(spd_b),   32'(m_spd[1]));
      check("b.lock",  32'(lock_b),  32'(m_lock[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic spawn(input logic [15:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    req       = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    req       = 1'b0;
  endtask

  initial begin
    logic [15:0] seq [5];
    int vcount;
    int r;
    seq = '{16'h0000, 16'h8000, 16'h4000, 16'h2000, 16'h9000};
    rst = 1'b1; seed_load = 1'b0; seed_in = 16'h0000; req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Free-running sequence from reset; pins both the RTL and the model.
    for (int i = 0; i < 5; i++) begin
      check("lfsr_seq",  32'(dut_a.lfsr_s), 32'(seq[i]));
      check("model_seq", 32'(m_lfsr[0]),    32'(seq[i]));
      check("rst_ready", 32'(ready_a), 32'd1);
      check("rst_valid", 32'(valid_a), 32'd0);
      check("rst_pos",   32'(pos_a),   32'd0);
      @(negedge clk);
    end

    // First-sample accept, speed floored from 0.
    spawn(16'h0020);
    check("s1_busy", 32'(ready_a), 32'd0);
    @(negedge clk);
    check("s1_valid", 32'(valid_a), 32'd1);
    check("s1_dir",   32'(dir_a),   32'd0);
    check("s1_pos",   32'(pos_a),   32'd1);
    check("s1_spd",   32'(spd_a),   32'd2);
    check("s1_model_pos", 32'(m_pos[0]), 32'd1);
    @(negedge clk);
    check("s1_pulse", 32'(valid_a), 32'd0);

    // One rejection (A) versus forced fallback (B, MAX_TRIES=1).
    spawn(16'h7FE0);
    @(negedge clk);
    check("s2_a_wait",  32'(valid_a), 32'd0);
    check("s2_b_valid", 32'(valid_b), 32'd1);
    check("s2_b_pos",   32'(pos_b),   32'd511);
    check("s2_b_dir",   32'(dir_b),   32'd0);
    check("s2_b_spd",   32'(spd_b),   32'd2);
    @(negedge clk);
    check("s2_a_valid", 32'(valid_a), 32'd1);
    check("s2_a_dir",   32'(dir_a),   32'd1);
    check("s2_a_pos",   32'(pos_a),   32'd511);
    check("s2_a_spd",   32'(spd_a),   32'd16);
    check("s2_model_spd", 32'(m_spd[0]), 32'd16);

    // Loading the lock-up value substitutes SEED.
    seed_load = 1'b1; seed_in = 16'hFFFF;
    @(negedge clk);
    seed_load = 1'b0;
    check("lk_lfsr",  32'(dut_a.lfsr_s), 32'h0000ACE1);
    check("lk_pulse", 32'(lock_a), 32'd1);
    @(negedge clk);
    check("lk_once",  32'(lock_a), 32'd0);

    // Stepping into all-ones is also recovered.
    seed_load = 1'b1; seed_in = 16'hFFFE;
    @(negedge clk);
    seed_load = 1'b0;
    check("lk2_fffe", 32'(dut_a.lfsr_s), 32'h0000FFFE);
    @(negedge clk);
    check("lk2_ffff", 32'(dut_a.lfsr_s), 32'h0000FFFF);
    check("lk2_nopulse", 32'(lock_a), 32'd0);
    @(negedge clk);
    check("lk2_seed",  32'(dut_a.lfsr_s), 32'h0000ACE1);
    check("lk2_pulse", 32'(lock_a), 32'd1);
    @(negedge clk);

    // req held high through SAMPLE yields exactly one valid.
    seed_load = 1'b1; seed_in = 16'h7FE0; req = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_a) vcount++;
      if (i == 2) req = 1'b0;
      @(negedge clk);
    end
    check("hold_one_valid", 32'(vcount), 32'd1);

    // Reset during SAMPLE aborts the request.
    spawn(16'h7FE0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(ready_a), 32'd1);
    check("abort_valid", 32'(valid_a), 32'd0);
    check("abort_pos",   32'(pos_a),   32'd0);
    check("abort_spd",   32'(spd_a),   32'd0);
    check("abort_lfsr",  32'(dut_a.lfsr_s), 32'd0);
    @(negedge clk);
    check("abort_novalid", 32'(valid_a), 32'd0);

    // Random phase, checked by the every-cycle compare.
    for (int c = 0; c < 3000; c++) begin
      req       = ($urandom % 4) == 0;
      seed_load = ($urandom % 12) == 0;
      r = $urandom % 8;
      case (r)
        0:       seed_in = 16'hFFFF;
        1:       seed_in = 16'hFFFE;
        2:       seed_in = 16'h7FE0;
        default: seed_in = 16'($urandom);
      endcase
      rst = ($urandom % 300) == 0;
      @(negedge clk);
    end
    rst = 1'b0; req = 1'b0; seed_load = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
